// File: rtl/stack_pkg.sv
// Shared command encoding and modulo-DEPTH pointer helpers for the synchronous stack.
package stack_pkg;

  typedef enum logic [1:0] {
    CMD_NOP  = 2'b00,
    CMD_PUSH = 2'b01,
    CMD_POP  = 2'b10,
    CMD_GET  = 2'b11
  } cmd_t;

  // Explicit wrap keeps these exact for DEPTH values that are not a power of two.
  function automatic int unsigned mod_inc(input int unsigned pos, input int unsigned depth);
    return (pos >= depth - 1) ? 0 : pos + 1;
  endfunction

  function automatic int unsigned mod_dec(input int unsigned pos, input int unsigned depth);
    return (pos == 0) ? depth - 1 : pos - 1;
  endfunction

  // (pos - 1 - off) mod depth, borrowing a full depth when the subtraction would go negative.
  function automatic int unsigned mod_back(input int unsigned pos, input int unsigned off,
                                           input int unsigned depth);
    return (pos > off) ? pos - 1 - off : pos + depth - 1 - off;
  endfunction

endpackage

// File: rtl/stack_mem.sv
// DEPTH x WIDTH register file: one synchronous write port, one combinational read port, synchronous clear.
module stack_mem #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 5,
  localparam int unsigned IW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             we,
  input  logic [IW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [IW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (clear) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Addresses beyond DEPTH-1 only occur on non-power-of-two depths and are never consumed.
  always_comb begin
    rdata = '0;
    if (32'(raddr) < DEPTH) rdata = mem[raddr];
  end

endmodule

// File: rtl/stack_sync_param.sv
// Parameterised synchronous stack with push/pop/indexed get, optional overwrite-on-full and error pulse.
module stack_sync_param
  import stack_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 5,
  parameter int unsigned WRAP  = 1,
  localparam int unsigned IW = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [1:0]       COMMAND,
  input  logic [IW-1:0]    INDEX,
  input  logic [WIDTH-1:0] DATA_IN,
  output logic [WIDTH-1:0] DATA_OUT,
  output logic             OUT_VALID,
  output logic             FULL,
  output logic             EMPTY,
  output logic [IW:0]      COUNT,
  output logic             ERROR
);

  localparam logic [IW:0] CNT_FULL = (IW + 1)'(DEPTH);

  cmd_t             cmd;
  logic [IW-1:0]    top_q, top_d;
  logic [IW:0]      count_q, count_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             we;
  logic [IW-1:0]    raddr;
  logic [WIDTH-1:0] rdata;
  logic             full, empty;

  assign cmd   = cmd_t'(COMMAND);
  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);

  stack_mem #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_mem (
    .clk  (CLK),
    .clear(RESET),
    .we   (we),
    .waddr(top_q),
    .wdata(DATA_IN),
    .raddr(raddr),
    .rdata(rdata)
  );

  always_comb begin
    top_d   = top_q;
    count_d = count_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    we      = 1'b0;
    raddr   = IW'(mod_dec(32'(top_q), DEPTH));

    case (cmd)
      CMD_PUSH: begin
        if (!full || WRAP != 0) begin
          we    = 1'b1;
          top_d = IW'(mod_inc(32'(top_q), DEPTH));
          if (!full) count_d = count_q + 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
      CMD_POP: begin
        if (empty) begin
          err_d = 1'b1;
        end else begin
          top_d   = raddr;
          count_d = count_q - 1'b1;
          data_d  = rdata;
          valid_d = 1'b1;
        end
      end
      CMD_GET: begin
        if ({1'b0, INDEX} < count_q) begin
          raddr   = IW'(mod_back(32'(top_q), 32'(INDEX), DEPTH));
          data_d  = rdata;
          valid_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      top_q   <= '0;
      count_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      top_q   <= top_d;
      count_q <= count_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign DATA_OUT  = data_q;
  assign OUT_VALID = valid_q;
  assign ERROR     = err_q;
  assign COUNT     = count_q;
  assign FULL      = full;
  assign EMPTY     = empty;

endmodule

// File: tb/tb_stack_sync_param.sv
// Directed and randomised checks of stack_sync_param for DEPTH=5 (WRAP 1/0) and DEPTH=8 against a queue model.
module tb_stack_sync_param;
  import stack_pkg::*;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [1:0] COMMAND;
  logic [2:0] INDEX;
  logic [3:0] DATA_IN;

  logic [3:0] dout  [3];
  logic       valid [3];
  logic       err   [3];
  logic       full  [3];
  logic       empty [3];
  logic [3:0] cnt   [3];

  always #5 CLK = ~CLK;

  stack_sync_param #(.WIDTH(4), .DEPTH(5), .WRAP(1)) dut_a (
    .CLK(CLK), .RESET(RESET), .COMMAND(COMMAND), .INDEX(INDEX), .DATA_IN(DATA_IN),
    .DATA_OUT(dout[0]), .OUT_VALID(valid[0]), .FULL(full[0]), .EMPTY(empty[0]),
    .COUNT(cnt[0]), .ERROR(err[0]));

  stack_sync_param #(.WIDTH(4), .DEPTH(5), .WRAP(0)) dut_b (
    .CLK(CLK), .RESET(RESET), .COMMAND(COMMAND), .INDEX(INDEX), .DATA_IN(DATA_IN),
    .DATA_OUT(dout[1]), .OUT_VALID(valid[1]), .FULL(full[1]), .EMPTY(empty[1]),
    .COUNT(cnt[1]), .ERROR(err[1]));

  stack_sync_param #(.WIDTH(4), .DEPTH(8), .WRAP(1)) dut_c (
    .CLK(CLK), .RESET(RESET), .COMMAND(COMMAND), .INDEX(INDEX), .DATA_IN(DATA_IN),
    .DATA_OUT(dout[2]), .OUT_VALID(valid[2]), .FULL(full[2]), .EMPTY(empty[2]),
    .COUNT(cnt[2]), .ERROR(err[2]));

  int checks = 0;
  int errors = 0;

  int mq [3][$];
  int exp_data  [3];
  int exp_valid [3];
  int exp_err   [3];
  int depth_of  [3] = '{5, 5, 8};
  int wrap_of   [3] = '{1, 0, 1};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model(input int k, input logic rst, input logic [1:0] cmd,
                       input int idx, input int din);
    int n;
    exp_valid[k] = 0;
    exp_err[k]   = 0;
    if (rst) begin
      mq[k].delete();
      exp_data[k] = 0;
      return;
    end
    n = mq[k].size();
    case (cmd)
      2'b01: begin
        if (n < depth_of[k]) mq[k].push_back(din);
        else if (wrap_of[k] != 0) begin
          void'(mq[k].pop_front());
          mq[k].push_back(din);
        end else exp_err[k] = 1;
      end
      2'b10: begin
        if (n == 0) exp_err[k] = 1;
        else begin
          exp_data[k]  = mq[k].pop_back();
          exp_valid[k] = 1;
        end
      end
      2'b11: begin
        if (idx < n) begin
          exp_data[k]  = mq[k][n - 1 - idx];
          exp_valid[k] = 1;
        end else exp_err[k] = 1;
      end
      default: ;
    endcase
  endtask

  task automatic step(input logic rst, input logic [1:0] cmd, input logic [2:0] idx,
                      input logic [3:0] din);
    RESET   = rst;
    COMMAND = cmd;
    INDEX   = idx;
    DATA_IN = din;
    @(posedge CLK);
    #1;
    for (int k = 0; k < 3; k++) begin
      model(k, rst, cmd, int'(idx), int'(din));
      check($sformatf("d%0d data", k),  32'(dout[k]),  32'(exp_data[k]));
      check($sformatf("d%0d valid", k), 32'(valid[k]), 32'(exp_valid[k]));
      check($sformatf("d%0d error", k), 32'(err[k]),   32'(exp_err[k]));
      check($sformatf("d%0d count", k), 32'(cnt[k]),   32'(mq[k].size()));
      check($sformatf("d%0d full", k),  32'(full[k]),  32'(mq[k].size() == depth_of[k]));
      check($sformatf("d%0d empty", k), 32'(empty[k]), 32'(mq[k].size() == 0));
    end
  endtask

  initial begin
    RESET = 1'b1; COMMAND = 2'b00; INDEX = '0; DATA_IN = '0;
    step(1'b1, CMD_NOP, 3'd0, 4'd0);
    step(1'b1, CMD_NOP, 3'd0, 4'd0);

    check("rst count", 32'(cnt[0]), 32'd0);
    check("rst empty", 32'(empty[0]), 32'd1);
    check("rst full", 32'(full[0]), 32'd0);
    check("rst data", 32'(dout[0]), 32'd0);
    check("rst valid", 32'(valid[0]), 32'd0);
    check("rst error", 32'(err[0]), 32'd0);

    // push 1,2,3 then pop three times
    step(1'b0, CMD_PUSH, 3'd0, 4'd1);
    step(1'b0, CMD_PUSH, 3'd0, 4'd2);
    step(1'b0, CMD_PUSH, 3'd0, 4'd3);
    check("lifo count3", 32'(cnt[0]), 32'd3);
    step(1'b0, CMD_POP, 3'd0, 4'd0);
    check("pop1 data", 32'(dout[0]), 32'd3);
    check("pop1 valid", 32'(valid[0]), 32'd1);
    step(1'b0, CMD_POP, 3'd0, 4'd0);
    check("pop2 data", 32'(dout[0]), 32'd2);
    check("pop2 valid", 32'(valid[0]), 32'd1);
    step(1'b0, CMD_POP, 3'd0, 4'd0);
    check("pop3 data", 32'(dout[0]), 32'd1);
    check("pop3 error", 32'(err[0]), 32'd0);
    check("pop3 empty", 32'(empty[0]), 32'd1);

    // pop on empty
    step(1'b0, CMD_POP, 3'd0, 4'd0);
    check("pop empty error", 32'(err[0]), 32'd1);
    check("pop empty valid", 32'(valid[0]), 32'd0);
    check("pop empty data held", 32'(dout[0]), 32'd1);
    check("pop empty count", 32'(cnt[0]), 32'd0);

    // fill to 5 and get top/bottom
    for (int v = 1; v <= 5; v++) step(1'b0, CMD_PUSH, 3'd0, 4'(v));
    step(1'b0, CMD_GET, 3'd0, 4'd0);
    check("get0 data", 32'(dout[0]), 32'd5);
    check("get0 valid", 32'(valid[0]), 32'd1);
    step(1'b0, CMD_GET, 3'd4, 4'd0);
    check("get4 data", 32'(dout[0]), 32'd1);
    check("full flag", 32'(full[0]), 32'd1);
    check("full count", 32'(cnt[0]), 32'd5);
    check("top wrapped", 32'(dut_a.top_q), 32'd0);

    // push 1..6 then pop 5: overwrite versus reject
    step(1'b1, CMD_NOP, 3'd0, 4'd0);
    for (int v = 1; v <= 5; v++) step(1'b0, CMD_PUSH, 3'd0, 4'(v));
    step(1'b0, CMD_PUSH, 3'd0, 4'd6);
    check("wrap1 push6 error", 32'(err[0]), 32'd0);
    check("wrap0 push6 error", 32'(err[1]), 32'd1);
    check("wrap1 push6 count", 32'(cnt[0]), 32'd5);
    for (int p = 0; p < 5; p++) begin
      step(1'b0, CMD_POP, 3'd0, 4'd0);
      check($sformatf("wrap1 pop%0d", p), 32'(dout[0]), 32'(6 - p));
      check($sformatf("wrap0 pop%0d", p), 32'(dout[1]), 32'(5 - p));
      check($sformatf("wrap1 pop%0d err", p), 32'(err[0]), 32'd0);
    end

    // get with INDEX == COUNT
    step(1'b1, CMD_NOP, 3'd0, 4'd0);
    step(1'b0, CMD_PUSH, 3'd0, 4'd9);
    step(1'b0, CMD_PUSH, 3'd0, 4'd10);
    step(1'b0, CMD_GET, 3'd1, 4'd0);
    check("get1 data", 32'(dout[0]), 32'd9);
    step(1'b0, CMD_GET, 3'd2, 4'd0);
    check("get oob error", 32'(err[0]), 32'd1);
    check("get oob valid", 32'(valid[0]), 32'd0);
    check("get oob data held", 32'(dout[0]), 32'd9);
    check("get oob count", 32'(cnt[0]), 32'd2);

    // reset overrides a held push
    step(1'b0, CMD_PUSH, 3'd0, 4'd7);
    step(1'b0, CMD_PUSH, 3'd0, 4'd8);
    check("pre-reset count", 32'(cnt[0]), 32'd4);
    step(1'b1, CMD_PUSH, 3'd0, 4'd7);
    check("mid reset count", 32'(cnt[0]), 32'd0);
    check("mid reset empty", 32'(empty[0]), 32'd1);
    check("mid reset data", 32'(dout[0]), 32'd0);
    step(1'b0, CMD_POP, 3'd0, 4'd0);
    check("post reset pop error", 32'(err[0]), 32'd1);
    step(1'b0, CMD_GET, 3'd0, 4'd0);
    check("post reset get error", 32'(err[0]), 32'd1);

    // random stream, all three instances compared against the queue model inside step
    for (int i = 0; i < 400; i++) begin
      int r;
      logic [1:0] c;
      r = $urandom_range(0, 9);
      c = (r == 0) ? 2'b00 : (r <= 4) ? 2'b01 : (r <= 7) ? 2'b10 : 2'b11;
      step(($urandom_range(0, 39) == 0), c, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stack_sync_param.md
STACK_SYNC_PARAM -- requirements
Module: stack_sync_param

Interface
REQ-001 Parameter WIDTH, default 4: data word width in bits, >=1.
REQ-002 Parameter DEPTH, default 5: number of entries, >=2; need not be a power of two.
REQ-003 Parameter WRAP, default 1: 1 = push-on-full overwrites oldest entry; 0 = push-on-full rejected.
REQ-004 Derived IW = $clog2(DEPTH): pointer and index width.
REQ-005 CLK  input  1  clock; all state changes on rising edge.
REQ-006 RESET  input  1  reset, synchronous, active-high.
REQ-007 COMMAND  input  2  00 nop, 01 push, 10 pop, 11 get.
REQ-008 INDEX  input  IW  get offset from top; 0 = most recent entry.
REQ-009 DATA_IN  input  WIDTH  push data.
REQ-010 DATA_OUT  output  WIDTH  registered pop/get result.
REQ-011 OUT_VALID  output  1  one-cycle pulse; DATA_OUT is new this cycle.
REQ-012 FULL  output  1  COUNT == DEPTH.
REQ-013 EMPTY  output  1  COUNT == 0.
REQ-014 COUNT  output  IW+1  number of valid entries, 0..DEPTH.
REQ-015 ERROR  output  1  one-cycle pulse; the command issued on the previous edge was illegal.

Function
REQ-016 COMMAND, INDEX and DATA_IN are sampled on each rising CLK edge; one command per cycle.
REQ-017 TOP points to the next free slot; it advances and retreats modulo DEPTH.
REQ-018 Push, not full: mem[TOP] <= DATA_IN; TOP <= (TOP+1) mod DEPTH; COUNT+1.
REQ-019 Push, full, WRAP=1: write and advance TOP as in REQ-018; COUNT stays DEPTH; the oldest entry is lost; ERROR stays 0.
REQ-020 Push, full, WRAP=0: no state change; ERROR=1 for one cycle.
REQ-021 Pop, not empty: TOP <= (TOP-1) mod DEPTH; DATA_OUT <= mem[(TOP-1) mod DEPTH]; COUNT-1; OUT_VALID=1 the next cycle.
REQ-022 Pop, empty: no state change; OUT_VALID=0; ERROR=1. Applies in both WRAP modes.
REQ-023 Get, INDEX < COUNT: DATA_OUT <= mem[(TOP-1-INDEX) mod DEPTH]; TOP and COUNT unchanged; OUT_VALID=1.
REQ-024 Get, INDEX >= COUNT (includes INDEX >= DEPTH): no state change; OUT_VALID=0; ERROR=1.
REQ-025 Latency: pop/get data appears on DATA_OUT exactly one cycle after the sampling edge.
REQ-026 DATA_OUT holds its last value whenever OUT_VALID=0.
REQ-027 OUT_VALID and ERROR are never both 1.
REQ-028 FULL, EMPTY and COUNT reflect state after the most recent edge and are registered (or decoded from registered COUNT), with no combinational path from inputs.
REQ-029 Modulo arithmetic is computed without relying on power-of-two truncation; borrow is handled explicitly when DEPTH is not 2^IW.
REQ-030 Nop: no state change; OUT_VALID=0; ERROR=0.

Reset
REQ-031 RESET=1 at an edge overrides any COMMAND in that cycle.
REQ-032 Reset values: TOP=0, COUNT=0, EMPTY=1, FULL=0, DATA_OUT=0, OUT_VALID=0, ERROR=0.
REQ-033 Memory contents are cleared to 0 on reset; a get after reset always errors, because COUNT=0.
REQ-034 Reset asserted mid-sequence: the cycle after the reset edge is the reset state, irrespective of pending commands.

Structure
REQ-035 Shared package stack_pkg holds the command enum typedef (CMD_NOP, CMD_PUSH, CMD_POP, CMD_GET) and the modulo-DEPTH increment/decrement functions.
REQ-036 Sub-module stack_mem holds the DEPTH x WIDTH register file: one synchronous write port, one combinational read port, and synchronous clear.
REQ-037 The top level holds TOP, COUNT, command decode, legality checks and the output registers.

Verification (WIDTH=4, DEPTH=5)
REQ-038 Reset, then push 1,2,3, then pop x3 -> DATA_OUT 3,2,1 with OUT_VALID each cycle; EMPTY=1 at end; ERROR never set.
REQ-039 Push 1..5, then get INDEX=0 and INDEX=4 -> 5 then 1; FULL=1, COUNT=5, TOP=0.
REQ-040 WRAP=1: push 1..6, then pop x5 -> 6,5,4,3,2, no ERROR. WRAP=0: same stimulus -> ERROR pulse on the 6th push; pops return 5,4,3,2,1.
REQ-041 Pop on empty, and get INDEX=2 with COUNT=2 -> ERROR=1, OUT_VALID=0, DATA_OUT and COUNT unchanged.
REQ-042 Push 7, push 8, then RESET with COMMAND=push held -> COUNT=0, EMPTY=1, DATA_OUT=0; a subsequent pop -> ERROR.
REQ-043 Random command stream against a reference queue model, across DEPTH in {5, 8} -> exact match of DATA_OUT, OUT_VALID, ERROR and COUNT every cycle.
